// File: rtl/srcnn_mul_pkg.sv
// Shared widths, helpers and operand bundle for the SRCNN
// shared-multiplier scheduler.
package srcnn_mul_pkg;

  localparam int MUL_A_W = 7;
  localparam int MUL_B_W = 19;
  localparam int MUL_P_W = 25;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int MUL_ID_W = clog2(4);

  typedef struct packed {
    logic [MUL_A_W-1:0]  a;
    logic [MUL_B_W-1:0]  b;
    logic [MUL_ID_W-1:0] id;
  } mul_op_t;

endpackage

// File: rtl/srcnn_rr_arb.sv
// Round-robin arbiter: picks the first requester after i_ptr,
// wrapping; purely combinational.
module srcnn_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  always_comb begin
    logic [ID_W-1:0] w_j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/srcnn_mul_share_ctrl.sv
// Two-stage pipeline sharing one multiplier among NUM_REQ
// requesters with round-robin grant and tagged responses.
module srcnn_mul_share_ctrl
  import srcnn_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_W     = MUL_A_W,
  parameter int B_W     = MUL_B_W,
  parameter int P_W     = MUL_P_W,
  parameter int ID_W    = clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   flush,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [P_W-1:0]         rsp_data,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);

  localparam int F_W = A_W + B_W;

  typedef struct packed {
    logic [A_W-1:0]  a;
    logic [B_W-1:0]  b;
    logic [ID_W-1:0] id;
  } s1_op_t;

  logic               r_s1_vld;
  s1_op_t             r_s1;
  logic               r_s2_vld;
  logic [P_W-1:0]     r_s2_p;
  logic [ID_W-1:0]    r_s2_id;
  logic [ID_W-1:0]    r_ptr;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_adv1;
  logic               w_adv2;
  logic               w_hs;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic [A_W-1:0]     w_a;
  logic [B_W-1:0]     w_b;
  logic [F_W-1:0]     w_full;

  srcnn_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_adv2    = !r_s2_vld || rsp_ready;
  assign w_adv1    = !r_s1_vld || w_adv2;
  assign req_ready = w_gnt & {NUM_REQ{w_adv1 & !flush}};
  assign w_hs      = w_any && w_adv1 && !flush;

  assign w_a    = req_a[w_idx*A_W +: A_W];
  assign w_b    = req_b[w_idx*B_W +: B_W];
  assign w_full = F_W'(r_s1.a) * F_W'(r_s1.b);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
    end else if (flush) begin
      r_s1_vld <= 1'b0;
    end else if (w_hs) begin
      r_s1_vld <= 1'b1;
      r_s1     <= '{a: w_a, b: w_b, id: w_idx};
    end else if (w_adv1) begin
      r_s1_vld <= 1'b0;
    end
  end

  // Flush wins over a pending response handshake.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s2_vld <= 1'b0;
      r_s2_p   <= '0;
      r_s2_id  <= '0;
    end else if (flush) begin
      r_s2_vld <= 1'b0;
    end else if (w_adv2) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_p  <= w_full[P_W-1:0];
        r_s2_id <= r_s1.id;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_ptr <= ID_W'(NUM_REQ - 1);
      r_cnt <= '0;
    end else if (w_hs) begin
      r_ptr <= w_idx;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign rsp_valid = r_s2_vld;
  assign rsp_data  = r_s2_p;
  assign rsp_id    = r_s2_id;
  assign busy      = r_s1_vld | r_s2_vld;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_srcnn_mul_share_ctrl.sv
// Directed and random stimulus against a queue-based reference
// of the shared-multiplier scheduler.
module tb_srcnn_mul_share_ctrl;
  import srcnn_mul_pkg::*;

  localparam int N  = 4;
  localparam int AW = 7;
  localparam int BW = 19;
  localparam int PW = 25;
  localparam int IW = 2;
  localparam int CW = 16;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a = '0;
  logic [N*BW-1:0] req_b = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IW-1:0]   rsp_id;
  logic [PW-1:0]   rsp_data;
  logic            busy;
  logic [CW-1:0]   op_count;

  srcnn_mul_share_ctrl dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    mul_op_t op;
    int      age;
  } ent_t;

  ent_t          q[$];
  int            m_ptr = N - 1;
  logic [CW-1:0] m_cnt = '0;
  int            hs_last = -1;
  int            n_eval = 0;
  int            n_fail = 0;
  logic [AW-1:0] op_a[N];
  logic [BW-1:0] op_b[N];

  function automatic logic [63:0] prod(input mul_op_t o);
    longint unsigned p;
    p = longint'(o.a) * longint'(o.b);
    return p % (64'd1 << PW);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = op_a[i];
      req_b[i*BW +: BW] = op_b[i];
    end
  endtask

  task automatic refill(input int prob, input logic [N-1:0] en);
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || hs_last == i) begin
        req_valid[i] = en[i] && ($urandom_range(99) < prob);
        op_a[i] = AW'($urandom);
        op_b[i] = BW'($urandom);
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr   = N - 1;
    m_cnt   = '0;
    hs_last = -1;
  endtask

  task automatic cycle();
    int         g;
    logic [N-1:0] er;
    logic       erv;
    logic       rhs;
    ent_t       e;
    pack();
    @(negedge ap_clk);
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (g < 0 && req_valid[j]) g = j;
    end
    er = '0;
    if (g >= 0 && (q.size() < 2 || rsp_ready) && !flush) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    erv = q.size() > 0 && q[0].age >= 2;
    chk("rsp_valid", 64'(rsp_valid), 64'(erv));
    if (erv) begin
      chk("rsp_id", 64'(rsp_id), 64'(q[0].op.id));
      chk("rsp_data", 64'(rsp_data), prod(q[0].op));
    end
    chk("busy", 64'(busy), 64'(q.size() > 0));
    chk("op_count", 64'(op_count), 64'(m_cnt));
    rhs = erv && rsp_ready;
    @(posedge ap_clk);
    hs_last = -1;
    if (flush) begin
      q.delete();
    end else begin
      if (rhs) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (er != '0) begin
        e.op  = '{a: op_a[g], b: op_b[g], id: IW'(g)};
        e.age = 1;
        q.push_back(e);
        m_ptr   = g;
        m_cnt   = m_cnt + CW'(1);
        hs_last = g;
      end
    end
    #1;
  endtask

  initial begin
    logic [CW-1:0] cnt0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    rsp_ready = 1'b1;
    cycle();

    // single op, all-ones operands
    op_a[0] = 7'd127;
    op_b[0] = 19'd524287;
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    cycle();
    chk("single_vld", 64'(rsp_valid), 64'd1);
    chk("single_id", 64'(rsp_id), 64'd0);
    chk("single_data", 64'(rsp_data), 64'd33030017);
    repeat (3) cycle();

    // all requesters streaming
    cnt0 = m_cnt;
    req_valid = '0;
    for (int c = 0; c < 8; c++) begin
      refill(100, 4'hF);
      cycle();
    end
    chk("rr8_cnt", 64'(op_count), 64'(cnt0 + CW'(8)));
    req_valid = '0;
    repeat (3) cycle();

    // backpressure with req1 streaming
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      refill(100, 4'b0010);
      cycle();
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      refill(100, 4'b0010);
      cycle();
    end
    req_valid = '0;
    repeat (3) cycle();

    // flush with both stages full
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      refill(100, 4'b0100);
      cycle();
    end
    flush = 1'b1;
    refill(100, 4'hF);
    cycle();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_rsp_valid", 64'(rsp_valid), 64'd0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      refill(100, 4'hF);
      cycle();
    end

    // async reset mid-stream
    for (int c = 0; c < 3; c++) begin
      refill(100, 4'hF);
      cycle();
    end
    ap_rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_rsp_id", 64'(rsp_id), 64'd0);
    chk("arst_rsp_data", 64'(rsp_data), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_op_count", 64'(op_count), 64'd0);
    model_reset();
    req_valid = 4'hF;
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    pack();
    #1;
    chk("arst_first_gnt", 64'(req_ready), 64'b0001);
    for (int c = 0; c < 4; c++) begin
      refill(100, 4'hF);
      cycle();
    end

    // random traffic
    for (int c = 0; c < 12000; c++) begin
      rsp_ready = ($urandom_range(3) != 0);
      flush = ($urandom_range(499) == 0);
      refill(60, 4'hF);
      cycle();
    end
    flush = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end

endmodule
